// File: rtl/pipeline_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package pipeline_fetch_pkg;

  // Number of fetched words that can wait for decode.
  localparam int FETCH_QUEUE_DEPTH = 2;

  // Width of the queue occupancy counter (holds 0..FETCH_QUEUE_DEPTH).
  localparam int FETCH_CNT_W = 2;

  // Occupancy value at which no further fetch may be issued.
  localparam logic [FETCH_CNT_W-1:0] FETCH_CNT_FULL = FETCH_CNT_W'(FETCH_QUEUE_DEPTH);

  // Request-side FSM states.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // nothing outstanding, may issue
    S_WAIT = 2'd1,  // one request outstanding, its data will be kept
    S_DROP = 2'd2   // one request outstanding, its data will be discarded
  } fetch_state_e;

endpackage

// File: rtl/pipeline_fetch_buffer.sv
// Two-entry FIFO of {pc, inst} pairs between the memory response and decode.
// Head outputs read as zero when the queue is empty.
module pipeline_fetch_buffer
  import pipeline_fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  input  logic [WIDTH-1:0]       pc_i,
  input  logic [WIDTH-1:0]       inst_i,
  output logic [FETCH_CNT_W-1:0] count_o,
  output logic [WIDTH-1:0]       head_pc_o,
  output logic [WIDTH-1:0]       head_inst_o
);

  logic [WIDTH-1:0]       pc_mem_q   [FETCH_QUEUE_DEPTH];
  logic [WIDTH-1:0]       inst_mem_q [FETCH_QUEUE_DEPTH];
  logic                   head_q, head_d;
  logic [FETCH_CNT_W-1:0] count_q, count_d;
  logic                   tail;
  logic                   do_pop;
  logic                   do_push;

  // With two slots the tail is the head plus the low occupancy bit; a full
  // queue wraps the tail back onto the head slot.
  assign tail    = head_q ^ count_q[0];
  assign do_pop  = pop_i && (count_q != '0) && !clear_i;
  assign do_push = push_i && !clear_i && ((count_q != FETCH_CNT_FULL) || do_pop);

  // Next head pointer and occupancy; clear wins over push and pop.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    head_d  = head_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = 1'b0;
      count_d = '0;
    end else begin
      head_d  = head_q ^ do_pop;
      count_d = count_q + FETCH_CNT_W'(do_push) - FETCH_CNT_W'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      head_q  <= 1'b0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
    end
  end

  // Entry storage, written at the tail on push.
  always_ff @(posedge clk) begin
    // NOTE: the data array is not reset; occupancy alone decides what is valid.
    if (do_push) begin
      pc_mem_q[tail]   <= pc_i;
      inst_mem_q[tail] <= inst_i;
    end
  end

  assign count_o     = count_q;
  assign head_pc_o   = (count_q == '0) ? '0 : pc_mem_q[head_q];
  assign head_inst_o = (count_q == '0) ? '0 : inst_mem_q[head_q];

endmodule

// File: rtl/pipeline_fetch.sv
// Instruction-fetch stage: owns the PC, keeps at most one memory request in
// flight, queues returned words and squashes work on a redirect.
module pipeline_fetch
  import pipeline_fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] inst_out,
  output logic                  bubble_out
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP     = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] RESET_PC_AL = {RESET_PC[DATA_WIDTH-1:2], 2'b00};

  fetch_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0]  pc_q, pc_d;
  logic [DATA_WIDTH-1:0]  issued_pc_q, issued_pc_d;
  logic                   req;
  logic                   push;
  logic                   pop;
  logic [FETCH_CNT_W-1:0] count;
  logic                   unused_target_bits;

  // The low target bits are dropped: the PC is always word aligned.
  assign unused_target_bits = ^redirect_target[1:0];

  // Next-state, request and push decisions; a redirect overrides the PC last.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    issued_pc_d = issued_pc_q;
    req         = 1'b0;
    push        = 1'b0;
    unique case (state_q)
      S_REQ: begin
        // Issuing only with free space guarantees the response can be queued.
        req = !rst && (count != FETCH_CNT_FULL) && !redirect;
        if (req && imem_ready) begin
          pc_d        = pc_q + PC_STEP;
          issued_pc_d = pc_q;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          push    = !redirect;
          state_d = S_REQ;
        end else if (redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
    if (redirect) begin
      pc_d = {redirect_target[DATA_WIDTH-1:2], 2'b00};
    end
  end

  // FSM state, PC and PC-of-outstanding-request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC_AL;
      issued_pc_q <= RESET_PC_AL;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      issued_pc_q <= issued_pc_d;
    end
  end

  // A redirect empties the queue, which also suppresses any pop that cycle.
  assign pop = !stall && (count != '0) && !redirect;

  pipeline_fetch_buffer #(
    .WIDTH (DATA_WIDTH)
  ) u_buffer (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (pop),
    .clear_i     (redirect),
    .pc_i        (issued_pc_q),
    .inst_i      (imem_rdata),
    .count_o     (count),
    .head_pc_o   (pc_out),
    .head_inst_o (inst_out)
  );

  assign imem_req   = req;
  assign imem_addr  = pc_q;
  assign bubble_out = (count == '0);

endmodule

// File: tb/tb_pipeline_fetch.sv
// Self-checking bench for pipeline_fetch: directed scenarios followed by a
// randomized run, compared against a queue-based reference model.
module tb_pipeline_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        bubble_out;

  int tests = 0;
  int fails = 0;

  pipeline_fetch #(
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .pc_out          (pc_out),
    .inst_out        (inst_out),
    .bubble_out      (bubble_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  // Reference model: fetch queue contents, architectural PC and the fate of
  // the single outstanding request.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_iss;
  bit          m_out;
  bit          m_sq;

  // Memory model: one pending request with a per-request latency.
  bit          mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          mem_lat;    // 0 = random latency 1..3
  bit          spur_en;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc     = 32'h0000_0000;
    m_iss    = 32'h0000_0000;
    m_out    = 1'b0;
    m_sq     = 1'b0;
    mem_pend = 1'b0;
    mem_cnt  = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".bubble"}, {31'd0, bubble_out}, {31'd0, mq.size() == 0});
    check({tag, ".pc"},     pc_out,   (mq.size() == 0) ? 32'h0 : mq[0].pc);
    check({tag, ".inst"},   inst_out, (mq.size() == 0) ? 32'h0 : mq[0].inst);
  endtask

  // One clock cycle: drive inputs, check request side, advance model, check outputs.
  task automatic step(input bit st, input bit rd, input logic [31:0] tgt, input bit rdy);
    bit          exp_req;
    bit          m_acc;
    bit          m_resp;
    bit          dut_acc;
    logic [31:0] acc_addr;
    bit          genuine;
    @(negedge clk);
    stall           = st;
    redirect        = rd;
    redirect_target = tgt;
    imem_ready      = rdy;
    genuine         = mem_pend && (mem_cnt == 0);
    if (genuine) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_at(mem_addr);
    end else begin
      imem_rvalid = !mem_pend && spur_en && ($urandom_range(0, 7) == 0);
      imem_rdata  = $urandom;
    end
    #1;
    exp_req = !m_out && (mq.size() < 2) && !rd;
    check("req", {31'd0, imem_req}, {31'd0, exp_req});
    check("addr", imem_addr, {m_pc[31:2], 2'b00});
    dut_acc  = imem_req && rdy;
    acc_addr = imem_addr;

    m_acc  = exp_req && rdy;
    m_resp = m_out && imem_rvalid;
    if (rd) begin
      mq.delete();
    end else begin
      if (!st && mq.size() > 0) void'(mq.pop_front());
      if (m_resp && !m_sq) mq.push_back('{m_iss, imem_rdata});
    end
    if (m_acc) begin
      m_out = 1'b1;
      m_sq  = 1'b0;
      m_iss = m_pc;
    end else if (m_resp) begin
      m_out = 1'b0;
      m_sq  = 1'b0;
    end else if (rd && m_out) begin
      m_sq = 1'b1;
    end
    if (rd)         m_pc = tgt & ~32'h3;
    else if (m_acc) m_pc = m_pc + 32'd4;

    @(posedge clk);
    #1;
    if (genuine)                     mem_pend = 1'b0;
    else if (mem_pend && mem_cnt > 0) mem_cnt--;
    if (dut_acc) begin
      mem_pend = 1'b1;
      mem_addr = acc_addr;
      mem_cnt  = (mem_lat == 0) ? $urandom_range(0, 2) : mem_lat - 1;
    end
    check_outputs("out");
  endtask

  // Run idle cycles until the model has a request outstanding (bounded).
  task automatic run_until_outstanding();
    int n;
    n = 0;
    while (!m_out && n < 20) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      n++;
    end
    check("wait_outstanding", {31'd0, m_out}, 32'd1);
  endtask

  // Run idle cycles until nothing is outstanding and the queue has room (bounded).
  task automatic run_until_can_issue();
    int n;
    n = 0;
    while ((m_out || mq.size() >= 2) && n < 20) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      n++;
    end
    check("wait_can_issue", {31'd0, !m_out && mq.size() < 2}, 32'd1);
  endtask

  initial begin
    rst             = 1'b1;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'h0;
    imem_ready      = 1'b0;
    imem_rvalid     = 1'b0;
    imem_rdata      = 32'h0;
    mem_lat         = 1;
    spur_en         = 1'b0;
    model_reset();

    // Reset state while rst is held.
    @(negedge clk);
    #1;
    check("rst.req",    {31'd0, imem_req},   32'd0);
    check("rst.bubble", {31'd0, bubble_out}, 32'd1);
    check("rst.pc",     pc_out,              32'd0);
    check("rst.inst",   inst_out,            32'd0);
    rst = 1'b0;

    // 1-cycle memory, no stall: addresses 0,4,8,... in order.
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Stall for 5 cycles while the queue fills, then drain.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect to 0x100 while a 3-cycle request is outstanding.
    mem_lat = 3;
    run_until_outstanding();
    step(1'b0, 1'b1, 32'h0000_0103, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect in the same cycle the memory is ready: nothing is accepted.
    mem_lat = 1;
    run_until_can_issue();
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // PC wraps from 0xFFFF_FFFC to 0.
    step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset pulsed while a request is outstanding.
    mem_lat = 3;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
    run_until_outstanding();
    @(negedge clk);
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    model_reset();
    check("midrst.req", {31'd0, imem_req}, 32'd0);
    check_outputs("midrst");
    @(negedge clk);
    #2;
    rst = 1'b0;
    mem_lat = 1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Randomized traffic: stalls, redirects, ready gaps, latencies, stray rvalid.
    mem_lat = 0;
    spur_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
           $urandom, ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
